// File: rtl/ahb_ram_slave.sv
// AHB-lite RAM responder: word-addressed SRAM with WAIT_CYCLES wait states per transfer
// and a two-cycle ERROR response for misaligned or out-of-window accesses.
module ahb_ram_slave #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                    WAIT_CYCLES = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  hsel_i,
  input  logic [ADDR_WIDTH-1:0] haddr_i,
  input  logic                  hwrite_i,
  input  logic [DATA_WIDTH-1:0] hwdata_i,
  output logic                  hready_o,
  output logic                  hresp_o,
  output logic [DATA_WIDTH-1:0] hrdata_o
);

  localparam int                    IW       = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] SPAN     = ADDR_WIDTH'(DEPTH * 4);
  localparam logic [3:0]            CNT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RESP, S_ERR1, S_ERR2} state_e;

  state_e                state_q;
  logic                  hsel_q;
  logic                  hwrite_q;
  logic [IW-1:0]         idx_q;
  logic [3:0]            cnt_q;
  logic                  hready_q;
  logic                  hresp_q;
  logic [DATA_WIDTH-1:0] hrdata_q;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] off_d;
  logic [IW-1:0]         idx_d;
  logic                  start_d;
  logic                  err_d;

  assign off_d   = haddr_i - BASE_ADDR;
  assign idx_d   = off_d[IW+1:2];
  assign start_d = hsel_i & ~hsel_q;
  assign err_d   = (haddr_i[1:0] != 2'b00) | (haddr_i < BASE_ADDR) | (off_d >= SPAN);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      hsel_q   <= 1'b0;
      hwrite_q <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= '0;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
      hrdata_q <= '0;
    end else begin
      hsel_q <= hsel_i;
      case (state_q)
        S_IDLE: begin
          hready_q <= 1'b1;
          hresp_q  <= 1'b0;
          hrdata_q <= '0;
          if (start_d) begin
            hwrite_q <= hwrite_i;
            idx_q    <= idx_d;
            if (err_d) begin
              state_q  <= S_ERR1;
              hready_q <= 1'b0;
              hresp_q  <= 1'b1;
            end else if (WAIT_CYCLES == 0) begin
              // No wait states: the read is captured straight from the request address.
              state_q  <= S_RESP;
              hrdata_q <= hwrite_i ? '0 : mem_q[idx_d];
            end else begin
              state_q  <= S_WAIT;
              cnt_q    <= CNT_INIT;
              hready_q <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q  <= S_RESP;
            hready_q <= 1'b1;
            hrdata_q <= hwrite_q ? '0 : mem_q[idx_q];
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          state_q  <= S_IDLE;
          hready_q <= 1'b1;
          hresp_q  <= 1'b0;
          hrdata_q <= '0;
        end
        S_ERR1: begin
          state_q  <= S_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= 1'b1;
        end
        S_ERR2: begin
          state_q  <= S_IDLE;
          hresp_q  <= 1'b0;
        end
        default: begin
          state_q  <= S_IDLE;
          hready_q <= 1'b1;
          hresp_q  <= 1'b0;
          hrdata_q <= '0;
        end
      endcase
    end
  end

  // Write data arrives during RESP and commits on the edge ending it; reset drops it.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == S_RESP && hwrite_q)
      mem_q[idx_q] <= hwdata_i;
  end

  assign hready_o = hready_q;
  assign hresp_o  = hresp_q;
  assign hrdata_o = hrdata_q;

endmodule

// File: tb/tb_ahb_ram_slave.sv
// Directed bench for ahb_ram_slave: three instances with WAIT_CYCLES = 1, 0 and 3.
module tb_ahb_ram_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  hsel_v = '0;
  logic [31:0] haddr = '0;
  logic        hwrite = 1'b0;
  logic [31:0] hwdata = '0;
  logic [2:0]  hready_v;
  logic [2:0]  hresp_v;
  logic [31:0] hrd0, hrd1, hrd2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ahb_ram_slave #(.WAIT_CYCLES(1)) u_w1 (
    .clk_i(clk), .rst_i(rst), .hsel_i(hsel_v[0]), .haddr_i(haddr), .hwrite_i(hwrite),
    .hwdata_i(hwdata), .hready_o(hready_v[0]), .hresp_o(hresp_v[0]), .hrdata_o(hrd0));
  ahb_ram_slave #(.WAIT_CYCLES(0)) u_w0 (
    .clk_i(clk), .rst_i(rst), .hsel_i(hsel_v[1]), .haddr_i(haddr), .hwrite_i(hwrite),
    .hwdata_i(hwdata), .hready_o(hready_v[1]), .hresp_o(hresp_v[1]), .hrdata_o(hrd1));
  ahb_ram_slave #(.WAIT_CYCLES(3)) u_w3 (
    .clk_i(clk), .rst_i(rst), .hsel_i(hsel_v[2]), .haddr_i(haddr), .hwrite_i(hwrite),
    .hwdata_i(hwdata), .hready_o(hready_v[2]), .hresp_o(hresp_v[2]), .hrdata_o(hrd2));

  function automatic int waits(int d);
    case (d)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic logic [31:0] rdata(int d);
    case (d)
      0:       return hrd0;
      1:       return hrd1;
      default: return hrd2;
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk_out(string nm, int d, logic rdy, logic rsp, logic [31:0] rd);
    chk({nm, ".hready"}, 32'(hready_v[d]), 32'(rdy));
    chk({nm, ".hresp"},  32'(hresp_v[d]),  32'(rsp));
    chk({nm, ".hrdata"}, rdata(d), rd);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transfer on instance d, checked cycle by cycle; returns in the first IDLE cycle after it.
  task automatic xfer(int d, logic [31:0] addr, logic wr, logic [31:0] wd,
                      logic [31:0] exp_rd, logic err, string nm, logic hold);
    tick();
    haddr = addr; hwrite = wr; hwdata = wd; hsel_v[d] = 1'b1;
    chk({nm, ".idle_rdy"}, 32'(hready_v[d]), 32'd1);
    tick();
    if (!hold) hsel_v[d] = 1'b0;
    if (err) begin
      chk_out({nm, ".err1"}, d, 1'b0, 1'b1, 32'h0);
      tick();
      chk_out({nm, ".err2"}, d, 1'b1, 1'b1, 32'h0);
    end else begin
      for (int i = 0; i < waits(d); i++) begin
        chk_out($sformatf("%s.wait%0d", nm, i), d, 1'b0, 1'b0, 32'h0);
        tick();
      end
      chk_out({nm, ".resp"}, d, 1'b1, 1'b0, wr ? 32'h0 : exp_rd);
    end
    tick();
    chk_out({nm, ".after"}, d, 1'b1, 1'b0, 32'h0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vt[14];

  initial begin
    vt[0]  = '{32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 32'h0,         1'b0};
    vt[1]  = '{32'h8000_0010, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vt[2]  = '{32'h8000_0000, 1'b1, 32'h1111_1111, 32'h0,         1'b0};
    vt[3]  = '{32'h8000_0FFC, 1'b1, 32'hA5A5_A5A5, 32'h0,         1'b0};
    vt[4]  = '{32'h8000_0FFC, 1'b0, 32'h0,         32'hA5A5_A5A5, 1'b0};
    vt[5]  = '{32'h8000_0000, 1'b0, 32'h0,         32'h1111_1111, 1'b0};
    vt[6]  = '{32'h8000_0002, 1'b1, 32'hBAD0_BAD0, 32'h0,         1'b1};
    vt[7]  = '{32'h8000_0012, 1'b1, 32'hBAD0_BAD0, 32'h0,         1'b1};
    vt[8]  = '{32'h8000_1000, 1'b1, 32'hBAD0_BAD0, 32'h0,         1'b1};
    vt[9]  = '{32'h7FFF_FFFC, 1'b1, 32'hBAD0_BAD0, 32'h0,         1'b1};
    vt[10] = '{32'h8000_0010, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vt[11] = '{32'h8000_0000, 1'b0, 32'h0,         32'h1111_1111, 1'b0};
    vt[12] = '{32'h8000_0FFC, 1'b0, 32'h0,         32'hA5A5_A5A5, 1'b0};
    vt[13] = '{32'h8000_0004, 1'b1, 32'h0404_0404, 32'h0,         1'b0};

    rst = 1'b1;
    tick(); tick();
    for (int d = 0; d < 3; d++) chk_out($sformatf("reset_d%0d", d), d, 1'b1, 1'b0, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++)
      xfer(0, vt[i].addr, vt[i].wr, vt[i].wdata, vt[i].rdata, vt[i].err,
           $sformatf("vec%0d", i), 1'b0);
    xfer(0, 32'h8000_0004, 1'b0, 32'h0, 32'h0404_0404, 1'b0, "b2b_rd", 1'b0);

    // Zero-wait instance: RESP in the cycle right after the start edge.
    xfer(1, 32'h8000_0040, 1'b1, 32'h0BAD_CAFE, 32'h0,         1'b0, "w0_wr", 1'b0);
    xfer(1, 32'h8000_0040, 1'b0, 32'h0,         32'h0BAD_CAFE, 1'b0, "w0_rd", 1'b0);
    xfer(1, 32'h8000_1000, 1'b0, 32'h0,         32'h0,         1'b1, "w0_err", 1'b0);

    // Three-wait instance, with hsel re-rising inside WAIT and then held through IDLE.
    xfer(2, 32'h8000_0020, 1'b1, 32'h7777_7777, 32'h0, 1'b0, "w3_wr", 1'b0);
    tick();
    haddr = 32'h8000_0020; hwrite = 1'b0; hsel_v[2] = 1'b1;
    tick();
    hsel_v[2] = 1'b0;
    chk_out("w3_rd.wait0", 2, 1'b0, 1'b0, 32'h0);
    tick();
    hsel_v[2] = 1'b1;
    chk_out("w3_rd.wait1", 2, 1'b0, 1'b0, 32'h0);
    tick();
    chk_out("w3_rd.wait2", 2, 1'b0, 1'b0, 32'h0);
    tick();
    chk_out("w3_rd.resp", 2, 1'b1, 1'b0, 32'h7777_7777);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out($sformatf("w3_held%0d", i), 2, 1'b1, 1'b0, 32'h0);
    end
    hsel_v[2] = 1'b0;

    // Held hsel across RESP: no second transfer may start.
    xfer(0, 32'h8000_0010, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, "hold_rd", 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("hold_idle%0d", i), 0, 1'b1, 1'b0, 32'h0);
    end
    hsel_v[0] = 1'b0;

    // Reset during WAIT of a write to word 5.
    xfer(0, 32'h8000_0014, 1'b1, 32'hCAFE_F00D, 32'h0, 1'b0, "w5_pre", 1'b0);
    tick();
    haddr = 32'h8000_0014; hwrite = 1'b1; hwdata = 32'h1234_5678; hsel_v[0] = 1'b1;
    tick();
    hsel_v[0] = 1'b0;
    chk_out("rstw.wait", 0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_out("rstw.after", 0, 1'b1, 1'b0, 32'h0);
    xfer(0, 32'h8000_0014, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, "w5_chk", 1'b0);

    // Reset during RESP of a write to word 6.
    xfer(0, 32'h8000_0018, 1'b1, 32'h600D_D00D, 32'h0, 1'b0, "w6_pre", 1'b0);
    tick();
    haddr = 32'h8000_0018; hwrite = 1'b1; hwdata = 32'h1234_5678; hsel_v[0] = 1'b1;
    tick();
    hsel_v[0] = 1'b0;
    tick();
    chk_out("rstr.resp", 0, 1'b1, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_out("rstr.after", 0, 1'b1, 1'b0, 32'h0);
    xfer(0, 32'h8000_0018, 1'b0, 32'h0, 32'h600D_D00D, 1'b0, "w6_chk", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
